// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream (length header, then words)
// into instruction-memory writes and holds the core in reset until loading ends.
module imem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iByteValid,
  input  logic [7:0]  iByte,
  output logic        oByteReady,
  output logic        oWrEn,
  output logic [31:0] oWrAddr,
  output logic [31:0] oWrData,
  output logic        oCoreRstN,
  output logic        oDone,
  output logic        oError
);

  localparam logic [31:0]         DEPTH   = 32'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t              state, next_state;
  logic [1:0]          byte_cnt;
  logic [31:0]         count;
  logic [31:0]         word;
  logic [31:0]         wr_addr;
  logic [31:0]         wr_data;
  logic [ADDR_WIDTH:0] idx;
  logic                byte_ready;
  logic                xfer;
  logic                last_byte;
  logic [31:0]         assembled;

  assign byte_ready = (state == HDR) || (state == DATA);
  assign xfer       = iByteValid && byte_ready;
  assign last_byte  = xfer && (byte_cnt == 2'd3);
  // Shift right so the first byte ends up in [7:0] after four transfers.
  assign assembled  = {iByte, word[31:8]};

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= HDR;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HDR: begin
        if (last_byte) begin
          if (assembled == 32'd0)       next_state = DONE;
          else if (assembled > DEPTH)   next_state = ERR;
          else                          next_state = DATA;
        end
      end
      DATA: begin
        if (last_byte) next_state = WRITE;
      end
      WRITE: begin
        next_state = ((32'(idx) + 32'd1) == count) ? DONE : DATA;
      end
      default: next_state = state;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      byte_cnt <= 2'd0;
      count    <= 32'd0;
      word     <= 32'd0;
      wr_addr  <= 32'd0;
      wr_data  <= 32'd0;
      idx      <= '0;
    end else begin
      if (!byte_ready)  byte_cnt <= 2'd0;
      else if (xfer)    byte_cnt <= byte_cnt + 2'd1;
      if (xfer) word <= assembled;
      if (state == HDR && last_byte) count <= assembled;
      // Write data/address are captured once per word so they hold between writes.
      if (state == DATA && last_byte) begin
        wr_data <= assembled;
        wr_addr <= BASE_ADDR + (32'(idx) << 2);
      end
      if (state == WRITE) idx <= idx + IDX_ONE;
    end
  end

  assign oByteReady = byte_ready;
  assign oWrEn      = (state == WRITE);
  assign oWrAddr    = wr_addr;
  assign oWrData    = wr_data;
  assign oCoreRstN  = (state == DONE);
  assign oDone      = (state == DONE);
  assign oError     = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as stimulus is
// driven and compared when the loader strobes the instruction memory.
module tb_imem_loader;

  localparam int          AW   = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iByteValid = 1'b0;
  logic [7:0]  iByte = 8'h00;
  logic        oByteReady, oWrEn, oCoreRstN, oDone, oError;
  logic [31:0] oWrAddr, oWrData;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  logic [63:0] exp_q[$];

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .iClk(iClk), .iRstN(iRstN), .iByteValid(iByteValid), .iByte(iByte),
    .oByteReady(oByteReady), .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oCoreRstN(oCoreRstN), .oDone(oDone), .oError(oError)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge iClk) begin
    if (iRstN && oWrEn) begin
      logic [63:0] e;
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", oWrAddr, e[63:32]);
        chk("wr_data", oWrData, e[31:0]);
      end
    end
  end

  // Called and returns just after a negedge.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    iByte = b;
    iByteValid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      rdy = oByteReady;
      @(posedge iClk);
      @(negedge iClk);
      if (rdy) begin
        iByteValid = 1'b0;
        return;
      end
    end
    iByteValid = 1'b0;
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) @(negedge iClk);
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_ready"}, 32'(oByteReady), 32'd1);
    chk({pfx, "_wren"},  32'(oWrEn),      32'd0);
    chk({pfx, "_addr"},  oWrAddr,         32'd0);
    chk({pfx, "_data"},  oWrData,         32'd0);
    chk({pfx, "_crst"},  32'(oCoreRstN),  32'd0);
    chk({pfx, "_done"},  32'(oDone),      32'd0);
    chk({pfx, "_err"},   32'(oError),     32'd0);
  endtask

  task automatic do_reset();
    iByteValid = 1'b0;
    iRstN = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    iRstN = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    int w0;
    do_reset();
    check_reset_vals("rst");

    // Single-word image; write must appear the cycle after the 8th byte.
    do_reset();
    w0 = wr_cnt;
    send_word(32'd1, 1'b0);
    exp_q.push_back({BASE, 32'h00A0_0513});
    send_word(32'h00A0_0513, 1'b0);
    chk("t1_wren", 32'(oWrEn), 32'd1);
    chk("t1_ready_in_write", 32'(oByteReady), 32'd0);
    @(negedge iClk);
    chk("t1_done", 32'(oDone), 32'd1);
    chk("t1_crst", 32'(oCoreRstN), 32'd1);
    chk("t1_ready", 32'(oByteReady), 32'd0);
    chk("t1_wren_off", 32'(oWrEn), 32'd0);

    // Bytes offered after DONE are never taken.
    iByteValid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      iByte = 8'($urandom);
      @(negedge iClk);
      chk("t6_ready", 32'(oByteReady), 32'd0);
      chk("t6_crst", 32'(oCoreRstN), 32'd1);
    end
    iByteValid = 1'b0;
    chk("t1_t6_writes", 32'(wr_cnt - w0), 32'd1);

    // Zero-length image.
    do_reset();
    w0 = wr_cnt;
    send_word(32'd0, 1'b0);
    chk("t2_done", 32'(oDone), 32'd1);
    chk("t2_crst", 32'(oCoreRstN), 32'd1);
    @(negedge iClk);
    chk("t2_writes", 32'(wr_cnt - w0), 32'd0);

    // N = DEPTH+1 is rejected.
    do_reset();
    w0 = wr_cnt;
    send_word(32'd17, 1'b0);
    chk("t3_err", 32'(oError), 32'd1);
    chk("t3_ready", 32'(oByteReady), 32'd0);
    chk("t3_crst", 32'(oCoreRstN), 32'd0);
    iByteValid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      iByte = 8'($urandom);
      @(negedge iClk);
    end
    iByteValid = 1'b0;
    chk("t3_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t3_err_hold", 32'(oError), 32'd1);

    // Full-capacity image with random valid gaps.
    do_reset();
    w0 = wr_cnt;
    send_word(32'd16, 1'b1);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({BASE + 32'(4 * i), 32'(i)});
      send_word(32'(i), 1'b1);
    end
    @(negedge iClk);
    chk("t4_writes", 32'(wr_cnt - w0), 32'd16);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t4_done", 32'(oDone), 32'd1);
    chk("t4_crst", 32'(oCoreRstN), 32'd1);

    // Asynchronous reset mid-word, then a fresh one-word image.
    do_reset();
    w0 = wr_cnt;
    send_word(32'd3, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 iRstN = 1'b0;
    #1 check_reset_vals("t5_async");
    @(negedge iClk);
    iRstN = 1'b1;
    exp_q.delete();
    send_word(32'd1, 1'b0);
    exp_q.push_back({BASE, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF, 1'b0);
    chk("t5_wren", 32'(oWrEn), 32'd1);
    @(negedge iClk);
    chk("t5_done", 32'(oDone), 32'd1);
    chk("t5_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
